seq_chunk_adder: RTL and testbench
==================================

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port sub, input, 1 bit: 0 selects input1+input2, 1 selects input1-input2; sampled with start.
REQ-007 SHALL have ports input1 and input2, each input, WIDTH bits: operands, captured when start is accepted.
REQ-008 SHALL have port out, output, WIDTH bits: the result.
REQ-009 SHALL have port carry_out, output, 1 bit: carry out of the MSB; for subtraction, 1 means no borrow.
REQ-010 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when out is valid.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1 at edge k, latch input1, input2 and sub, set the chunk index to 0, set carry-in to sub, and enter RUN.
REQ-014 SHALL, on each RUN cycle, add chunk[i] of A to chunk[i] of B' plus the running carry, where B' = sub ? ~input2 : input2; it SHALL write the sum into bits [i*CHUNK +: CHUNK] of out and register the chunk carry.
REQ-015 SHALL, after NCHUNK RUN cycles, enter DONE; done=1 for exactly one cycle (edge k+NCHUNK+1), then return to IDLE.
REQ-016 SHALL drive carry_out from the final chunk carry when entering DONE.
REQ-017 SHALL hold out and carry_out stable from DONE until the next accepted start.
REQ-018 SHALL ignore start in RUN and DONE: no operand recapture and no restart.
REQ-019 SHALL wrap results modulo 2^WIDTH; carry_out is the only overflow indication unless REQ-025 applies.
REQ-020 SHALL accept start in the IDLE cycle directly following DONE, giving a back-to-back throughput of one result per NCHUNK+2 cycles.
REQ-021 SHALL produce the correct result when NCHUNK=1 (CHUNK=WIDTH), with a latency of 2 cycles.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, enter IDLE and set out=0, carry_out=0, busy=0, done=0 and the chunk index to 0; rst overrides start.
REQ-023 SHALL, when rst is asserted mid-RUN, abort the operation with no done pulse, leaving out=0.

Configuration
REQ-024 SHALL use the macro ADDER_FLAGS_EN.
REQ-025 SHALL, with ADDER_FLAGS_EN defined, add outputs zero, negative and overflow (1 bit each, reset 0, updated on entering DONE, held with out). zero = (out==0); negative = out[WIDTH-1]; overflow = signed two's-complement overflow of the selected operation.
REQ-026 SHALL, with ADDER_FLAGS_EN undefined, omit these three ports and their logic entirely; all other behaviour is unchanged.

Verification (WIDTH=32, CHUNK=8)
REQ-027 SHALL cover: start, sub=0, 10000+20000 -> busy for 4 cycles, done at start+5, out=30000, carry_out=0.
REQ-028 SHALL cover: 0xFFFFFFFF+1 -> out=0, carry_out=1; with flags, zero=1 and overflow=0.
REQ-029 SHALL cover: sub=1, 10000-30000 -> out=0xFFFFB1E0, carry_out=0; with flags, negative=1.
REQ-030 SHALL cover: 0x7FFFFFFF+1 -> out=0x80000000, carry_out=0; with flags, overflow=1 and negative=1.
REQ-031 SHALL cover: start pulsed again with new operands during RUN and DONE -> ignored, and the first result is unaltered.
REQ-032 SHALL cover: rst asserted on the 2nd RUN cycle -> next cycle IDLE, out=0, no done pulse; a following start of 10000000+2000000 -> out=12000000.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/subtract, CHUNK bits per cycle, LSB chunk first.
// Optional zero/negative/overflow flag outputs are enabled by defining ADDER_FLAGS_EN.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             busy,
  output logic             done
`ifdef ADDER_FLAGS_EN
  ,
  output logic             zero,
  output logic             negative,
  output logic             overflow
`endif
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, w_res;
  logic [IW-1:0] r_idx;
  logic r_carry, w_last;
  logic [CHUNK:0] w_sum;
  assign w_last = r_idx == LAST;
  assign w_sum = {1'b0, r_a[r_idx*CHUNK +: CHUNK]} + {1'b0, r_b[r_idx*CHUNK +: CHUNK]} + (CHUNK+1)'(r_carry);
  // On the last chunk w_res is the complete result, so flags can be taken from it directly.
  always_comb begin
    w_res = out;
    w_res[r_idx*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE ? (start ? RUN : IDLE) : r_state == RUN ? (w_last ? DONE : RUN) : IDLE;
    busy = r_state == RUN;
    done = r_state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      carry_out <= 1'b0;
      r_idx <= '0;
      r_carry <= 1'b0;
      r_a <= '0;
      r_b <= '0;
    end else if (r_state == IDLE && start) begin
      r_a <= input1;
      r_b <= sub ? ~input2 : input2;
      r_idx <= '0;
      r_carry <= sub;
    end else if (r_state == RUN) begin
      out <= w_res;
      r_carry <= w_sum[CHUNK];
      r_idx <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) carry_out <= w_sum[CHUNK];
    end
  end
`ifdef ADDER_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      zero <= w_res == '0;
      negative <= w_res[WIDTH-1];
      overflow <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
    end
  end
`endif
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed and random operations checked against an arithmetic model.
module tb_seq_chunk_adder;
  localparam int W = 32;
  localparam int C = 8;
  localparam int N = W / C;
  logic clk = 1'b0;
  logic rst, start, sub;
  logic [W-1:0] input1, input2, out;
  logic carry_out, busy, done;
`ifdef ADDER_FLAGS_EN
  logic zero, negative, overflow;
`endif
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .input1(input1), .input2(input2), .out(out),
    .carry_out(carry_out), .busy(busy), .done(done)
`ifdef ADDER_FLAGS_EN
    , .zero(zero), .negative(negative), .overflow(overflow)
`endif
  );
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Called at a negedge with the DUT idle; returns at the negedge after the done pulse.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit poke);
    logic [W-1:0] eo;
    logic ec;
    longint t;
    eo = s ? a - b : a + b;
    ec = s ? (a >= b) : (longint'(a) + longint'(b) > 64'hFFFFFFFF);
    t = s ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
    start = 1'b1; sub = s; input1 = a; input2 = b;
    @(negedge clk);
    if (poke) begin
      input1 = ~a; input2 = b ^ 32'h5555_5555; sub = ~s;
    end else start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      @(negedge clk);
    end
    chk("done", done, 1);
    chk("busy_in_done", busy, 0);
    chk("out", out, eo);
    chk("carry_out", carry_out, ec);
`ifdef ADDER_FLAGS_EN
    chk("zero", zero, eo == 0);
    chk("negative", negative, eo[W-1]);
    chk("overflow", overflow, t != longint'($signed(eo)));
`endif
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("out_hold", out, eo);
    chk("carry_hold", carry_out, ec);
  endtask
  initial begin
    rst = 1'b1; start = 1'b1; sub = 1'b0; input1 = 32'd5; input2 = 32'd6;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    op(32'd10000, 32'd20000, 1'b0, 1'b0);
    op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    op(32'd10000, 32'd30000, 1'b1, 1'b0);
    chk("sub_literal", out, 32'hFFFF_B1E0);
    op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    chk("ovf_literal", out, 32'h8000_0000);
    op(32'd1234, 32'd5678, 1'b0, 1'b1);
    chk("poke_literal", out, 32'd6912);
    op(32'd0, 32'd0, 1'b1, 1'b0);
    op(32'h8000_0000, 32'd1, 1'b1, 1'b0);
    start = 1'b1; sub = 1'b0; input1 = 32'hAAAA_AAAA; input2 = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out", out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    op(32'd10000000, 32'd2000000, 1'b0, 1'b0);
    chk("after_abort", out, 32'd12000000);
    for (int i = 0; i < 25; i++)
      op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
